stack_controller: RTL

- Sequences Stack_Memory for the single-cycle core: owns the stack pointer and drives the memory's SP and StackWriteSrc inputs.
- Accepts one stack command at a time from the control unit through a valid/ready handshake: push, pop, binary-op, call, return or clear.
- Detects overflow and underflow.
- Stack grows downward: empty when SP == DEPTH. Top of stack is mem[SP]; the second entry is mem[SP+1]. These correspond to Stack_Memory read1 and read2.

---
 rtl/stack_cmd_if.sv | 11 +
 rtl/stack_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/stack_cmd_if.sv
// Command handshake between the control unit and the stack controller.
// Master issues commands; slave (the controller) raises cmd_ready when it can accept one.
interface stack_cmd_if;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [1:0] cmd_src;
    logic       cmd_ready;

    modport master (output cmd_valid, cmd_op, cmd_src, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_src, output cmd_ready);
endinterface

// File: rtl/stack_controller.sv
// Stack pointer owner and write sequencer for Stack_Memory (downward-growing stack).
// One command at a time: IDLE accepts, WR drives the memory write, DONE pulses completion.
module stack_controller #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    stack_cmd_if.slave       cmd,
    input  logic [31:0]      read1,
    output logic [1:0]       stack_write_src,
    output logic [31:0]      sp,
    output logic [31:0]      pop_data,
    output logic             done,
    output logic             err,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow_err,
    output logic             underflow_err
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam logic [SP_W-1:0] SP_EMPTY = SP_W'(DEPTH);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_BINOP = 3'b011;
    localparam logic [2:0] OP_CALL  = 3'b100;
    localparam logic [2:0] OP_RET   = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;

    localparam logic [1:0] SRC_ALU = 2'b01;
    localparam logic [1:0] SRC_PC  = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [1:0]      src_q, src_d;
    logic [31:0]     pop_q, pop_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            is_full, is_empty;
    logic [CNT_W-1:0] cnt;

    assign is_full  = (sp_q == '0);
    assign is_empty = (sp_q == SP_EMPTY);
    assign cnt      = CNT_W'(SP_EMPTY - sp_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sp_q    <= SP_EMPTY;
            src_q   <= 2'b00;
            pop_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            src_q   <= src_d;
            pop_q   <= pop_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // SP is committed at accept, so WR already presents the target address to the memory.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        src_d   = src_q;
        pop_d   = pop_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                    case (cmd.cmd_op)
                        OP_PUSH, OP_CALL: begin
                            if (is_full) begin
                                ovf_d = 1'b1;
                                err_d = 1'b1;
                            end else begin
                                sp_d    = sp_q - SP_W'(1);
                                src_d   = (cmd.cmd_op == OP_CALL) ? SRC_PC : cmd.cmd_src;
                                state_d = WR;
                            end
                        end
                        OP_POP, OP_RET: begin
                            if (is_empty) begin
                                unf_d = 1'b1;
                                err_d = 1'b1;
                            end else begin
                                pop_d = read1;
                                sp_d  = sp_q + SP_W'(1);
                            end
                        end
                        OP_BINOP: begin
                            if (cnt < CNT_W'(2)) begin
                                unf_d = 1'b1;
                                err_d = 1'b1;
                            end else begin
                                sp_d    = sp_q + SP_W'(1);
                                src_d   = SRC_ALU;
                                state_d = WR;
                            end
                        end
                        OP_CLEAR: begin
                            sp_d  = SP_EMPTY;
                            ovf_d = 1'b0;
                            unf_d = 1'b0;
                        end
                        OP_NOP: ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd.cmd_ready   = (state_q == IDLE);
    assign stack_write_src = (state_q == WR) ? src_q : 2'b00;
    assign sp              = 32'(sp_q);
    assign pop_data        = pop_q;
    assign done            = (state_q == DONE);
    assign err             = (state_q == DONE) && err_q;
    assign full            = is_full;
    assign empty           = is_empty;
    assign count           = cnt;
    assign overflow_err    = ovf_q;
    assign underflow_err   = unf_q;
endmodule
